// File: rtl/tnn_pkg.sv
// Shared types and helpers for the ternary neuron accumulator.
// Holds the activation codes, the frame FSM states and the threshold function.
package tnn_pkg;

  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_NEG  = 2'b11;
  localparam logic [1:0] ACT_ZERO = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } tnn_state_e;

  // Operands arrive sign-extended to 32 bits so that one function serves any ACC_W.
  // The upper threshold is tested first, so +1 wins when thr_lo >= thr_hi.
  function automatic logic [1:0] ternary_of(input logic signed [31:0] acc,
                                            input logic signed [31:0] thr_hi,
                                            input logic signed [31:0] thr_lo);
    if (acc >= thr_hi) return ACT_POS;
    if (acc <= thr_lo) return ACT_NEG;
    return ACT_ZERO;
  endfunction

endpackage

// File: rtl/tnn_sat_add.sv
// Signed ACC_W adder used for the accumulate step.
// Defining TNN_ACC_SATURATE_EN clamps overflow; without it the sum wraps.
module tnn_sat_add #(
  parameter int unsigned ACC_W = 10
) (
  input  logic signed [ACC_W-1:0] i_a,
  input  logic signed [ACC_W-1:0] i_b,
  output logic signed [ACC_W-1:0] o_sum
);

  logic signed [ACC_W-1:0] w_wrap;
  logic                    w_ovf;

  assign w_wrap = i_a + i_b;
  // Overflow is only possible when both operands share a sign that the result lost.
  assign w_ovf  = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_wrap[ACC_W-1] != i_a[ACC_W-1]);

`ifdef TNN_ACC_SATURATE_EN
  always_comb begin
    o_sum = w_wrap;
    if (w_ovf) begin
      o_sum = i_a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  logic w_ovf_unused;
  assign w_ovf_unused = w_ovf;
  assign o_sum        = w_wrap;
`endif

endmodule

// File: rtl/ternary_neuron_acc.sv
// Accumulates (pc_pos - pc_neg) over NUM_BEATS beats and thresholds into a ternary activation.
// Accumulator saturation is selected at build time by TNN_ACC_SATURATE_EN (see tnn_sat_add).
module ternary_neuron_acc
  import tnn_pkg::*;
#(
  parameter int unsigned PC_W      = 5,
  parameter int unsigned NUM_BEATS = 4,
  parameter int unsigned ACC_W     = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PC_W-1:0]         pc_pos,
  input  logic [PC_W-1:0]         pc_neg,
  input  logic signed [ACC_W-1:0] thr_hi,
  input  logic signed [ACC_W-1:0] thr_lo,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_act,
  output logic signed [ACC_W-1:0] out_acc
);

  tnn_state_e              r_state, w_state_d;
  logic [7:0]              r_cnt;
  logic signed [ACC_W-1:0] r_acc, r_thr_hi, r_thr_lo, r_out_acc;
  logic [1:0]              r_out_act;

  logic                    w_accept, w_first, w_last;
  logic [7:0]              w_cnt_next;
  logic signed [PC_W:0]    w_diff_n;
  logic signed [ACC_W-1:0] w_diff, w_sum, w_acc_next, w_thr_hi, w_thr_lo;
  logic [1:0]              w_act_next;

  assign w_diff_n = $signed({1'b0, pc_pos}) - $signed({1'b0, pc_neg});
  assign w_diff   = ACC_W'(w_diff_n);

  tnn_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .i_a   (r_acc),
    .i_b   (w_diff),
    .o_sum (w_sum)
  );

  // in_ready is held low while reset is asserted, even though the state reads IDLE.
  assign in_ready  = rst_n && ((r_state != OUT) || out_ready);
  assign out_valid = (r_state == OUT);
  assign out_act   = r_out_act;
  assign out_acc   = r_out_acc;

  // An accept outside ACC always opens a new frame, including the OUT-state overlap.
  assign w_accept   = in_valid && in_ready;
  assign w_first    = w_accept && (r_state != ACC);
  assign w_acc_next = w_first ? w_diff : w_sum;
  assign w_cnt_next = w_first ? 8'd1 : r_cnt + 8'd1;
  assign w_last     = (w_cnt_next == 8'(NUM_BEATS));
  assign w_thr_hi   = w_first ? thr_hi : r_thr_hi;
  assign w_thr_lo   = w_first ? thr_lo : r_thr_lo;
  assign w_act_next = ternary_of(32'(w_acc_next), 32'(w_thr_hi), 32'(w_thr_lo));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_state_d = w_last ? OUT : ACC;
      ACC:  if (w_accept && w_last) w_state_d = OUT;
      OUT: begin
        if (w_accept)       w_state_d = w_last ? OUT : ACC;
        else if (out_ready) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_thr_hi  <= '0;
      r_thr_lo  <= '0;
      r_out_acc <= '0;
      r_out_act <= ACT_ZERO;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
      end
      if (w_first) begin
        r_thr_hi <= thr_hi;
        r_thr_lo <= thr_lo;
      end
      if (w_accept && w_last) begin
        r_out_acc <= w_acc_next;
        r_out_act <= w_act_next;
      end
    end
  end

endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Directed bench for ternary_neuron_acc; a second ACC_W=6 instance covers overflow.
// Overflow expectations follow TNN_ACC_SATURATE_EN.
module tb_ternary_neuron_acc;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [4:0]        pc_pos, pc_neg;
  logic signed [9:0] thr_hi, thr_lo, out_acc;
  logic [1:0]        out_act;

  logic              v_in_valid, v_in_ready, v_out_valid, v_out_ready;
  logic [4:0]        v_pc_pos, v_pc_neg;
  logic signed [5:0] v_thr_hi, v_thr_lo, v_out_acc;
  logic [1:0]        v_out_act;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ternary_neuron_acc #(.PC_W(5), .NUM_BEATS(4), .ACC_W(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pc_pos(pc_pos), .pc_neg(pc_neg), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act), .out_acc(out_acc)
  );

  ternary_neuron_acc #(.PC_W(5), .NUM_BEATS(4), .ACC_W(6)) u_ovf (
    .clk(clk), .rst_n(rst_n), .in_valid(v_in_valid), .in_ready(v_in_ready),
    .pc_pos(v_pc_pos), .pc_neg(v_pc_neg), .thr_hi(v_thr_hi), .thr_lo(v_thr_lo),
    .out_valid(v_out_valid), .out_ready(v_out_ready), .out_act(v_out_act),
    .out_acc(v_out_acc)
  );

  typedef struct {
    logic [3:0][4:0] pos;
    logic [3:0][4:0] neg;
    int              hi;
    int              lo;
    int              stall;
    int              exp_acc;
    logic [1:0]      exp_act;
  } frame_t;

  frame_t vec[7];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // out_act must never carry the unused code.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (out_act == 2'b10 || v_out_act == 2'b10) begin
        errors++;
        $display("FAIL act_code_10 actual=%b/%b required=not 10", out_act, v_out_act);
      end
    end
  end

  task automatic send_beat(input logic [4:0] p, input logic [4:0] n, input int hi, input int lo);
    int t;
    in_valid = 1'b1;
    pc_pos   = p;
    pc_neg   = n;
    thr_hi   = 10'(hi);
    thr_lo   = 10'(lo);
    t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    chk("beat_ready", int'(in_ready), 1);
    step();
  endtask

  task automatic run_frame(input int idx);
    frame_t f;
    int     acc0;
    f = vec[idx];
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      // Later beats carry bogus thresholds that must be ignored.
      if (b == 0) send_beat(f.pos[b], f.neg[b], f.hi, f.lo);
      else        send_beat(f.pos[b], f.neg[b], -512, 511);
      if (b < 3) chk($sformatf("f%0d_no_early_valid", idx), int'(out_valid), 0);
    end
    in_valid = 1'b0;
    chk($sformatf("f%0d_valid", idx), int'(out_valid), 1);
    chk($sformatf("f%0d_acc", idx), int'(out_acc), f.exp_acc);
    chk($sformatf("f%0d_act", idx), int'(out_act), int'(f.exp_act));
    acc0 = int'(out_acc);
    for (int s = 0; s < f.stall; s++) begin
      step();
      chk($sformatf("f%0d_stall_valid", idx), int'(out_valid), 1);
      chk($sformatf("f%0d_stall_acc", idx), int'(out_acc), acc0);
      chk($sformatf("f%0d_stall_act", idx), int'(out_act), int'(f.exp_act));
      chk($sformatf("f%0d_stall_ready", idx), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk($sformatf("f%0d_drained", idx), int'(out_valid), 0);
  endtask

  initial begin
    vec[0] = '{pos: {5'd0, 5'd3, 5'd5, 5'd10}, neg: {5'd1, 5'd0, 5'd5, 5'd2},
               hi: 8, lo: -8, stall: 1, exp_acc: 10, exp_act: 2'b01};
    vec[1] = '{pos: {5'd0, 5'd0, 5'd0, 5'd0}, neg: {5'd22, 5'd22, 5'd22, 5'd22},
               hi: 50, lo: -50, stall: 5, exp_acc: -88, exp_act: 2'b11};
    vec[2] = '{pos: {5'd3, 5'd3, 5'd3, 5'd3}, neg: {5'd3, 5'd3, 5'd3, 5'd3},
               hi: 1, lo: -1, stall: 0, exp_acc: 0, exp_act: 2'b00};
    vec[3] = '{pos: {5'd7, 5'd7, 5'd7, 5'd7}, neg: {5'd7, 5'd7, 5'd7, 5'd7},
               hi: -5, lo: 5, stall: 0, exp_acc: 0, exp_act: 2'b01};
    vec[4] = '{pos: {5'd0, 5'd0, 5'd0, 5'd20}, neg: {5'd5, 5'd5, 5'd5, 5'd0},
               hi: 5, lo: -5, stall: 0, exp_acc: 5, exp_act: 2'b01};
    vec[5] = '{pos: {5'd0, 5'd0, 5'd5, 5'd0}, neg: {5'd1, 5'd9, 5'd0, 5'd5},
               hi: 20, lo: -10, stall: 2, exp_acc: -10, exp_act: 2'b11};
    vec[6] = '{pos: {5'd1, 5'd1, 5'd1, 5'd1}, neg: {5'd0, 5'd0, 5'd0, 5'd0},
               hi: 5, lo: -5, stall: 0, exp_acc: 4, exp_act: 2'b00};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_pos = '0; pc_neg = '0; thr_hi = '0; thr_lo = '0;
    v_in_valid = 1'b0; v_out_ready = 1'b0; v_pc_pos = '0; v_pc_neg = '0;
    v_thr_hi = '0; v_thr_lo = '0;

    // Reset state
    repeat (2) step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_act", int'(out_act), 0);
    chk("rst_out_acc", int'(out_acc), 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);

    foreach (vec[i]) run_frame(i);

    // Back-to-back frames with continuous valid/ready
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      send_beat(5'(k / 4 + 1), 5'd0, 10, -10);
      chk($sformatf("b2b_valid_%0d", k), int'(out_valid), (k % 4 == 3) ? 1 : 0);
      if (k % 4 == 3) begin
        chk($sformatf("b2b_acc_%0d", k), int'(out_acc), 4 * (k / 4 + 1));
        chk($sformatf("b2b_act_%0d", k), int'(out_act), (k == 11) ? 1 : 0);
      end
    end
    in_valid = 1'b0;
    step();
    chk("b2b_drained", int'(out_valid), 0);
    out_ready = 1'b0;

    // Mid-frame reset discards the partial accumulation
    send_beat(5'd20, 5'd0, 8, -8);
    send_beat(5'd20, 5'd0, 8, -8);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    step();
    rst_n = 1'b1;
    #1;
    run_frame(0);

    // Overflow on the narrow instance
    v_thr_hi = 6'sd10;
    v_thr_lo = -6'sd10;
    v_pc_pos = 5'd31;
    v_pc_neg = 5'd0;
    v_in_valid = 1'b1;
    repeat (4) step();
    v_in_valid = 1'b0;
    chk("ovf_valid", int'(v_out_valid), 1);
`ifdef TNN_ACC_SATURATE_EN
    chk("ovf_acc", int'(v_out_acc), 31);
    chk("ovf_act", int'(v_out_act), 1);
`else
    chk("ovf_acc", int'(v_out_acc), -4);
    chk("ovf_act", int'(v_out_act), 0);
`endif
    v_out_ready = 1'b1;
    step();
    chk("ovf_drained", int'(v_out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
